network_output_decoder: RTL and testbench
=========================================

NETWORK_OUTPUT_DECODER -- requirements
Module: network_output_decoder

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 8, the width of the network output integer.
REQ-002 SHALL have parameter WINDOW_LOG2, default 2, the log2 of the samples per averaging window.
REQ-003 SHALL have parameter THRESHOLD, default ((1<<INT_WIDTH)-1)/2, the decision threshold on the window mean.
REQ-004 SHALL have parameter HYST, default 16, the hysteresis half-band (used only when DECODER_HYST_EN is defined).
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, which qualifies in_value this cycle.
REQ-008 SHALL have port in_value, input, INT_WIDTH, the network output integer (unsigned).
REQ-009 SHALL have port out_valid, output, 1, result pending.
REQ-010 SHALL have port out_ready, input, 1, consumer accept.
REQ-011 SHALL have port out_mean, output, INT_WIDTH, the window mean.
REQ-012 SHALL have port out_bit, output, 1, the binary decision.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when an unconsumed result is overwritten.

Function
REQ-014 SHALL accumulate in_value into an (INT_WIDTH+WINDOW_LOG2)-bit accumulator on every cycle with in_valid=1 and ignore cycles with in_valid=0.
REQ-015 SHALL count accepted samples in a WINDOW_LOG2-bit counter that wraps to 0 after 2^WINDOW_LOG2 samples.
REQ-016 SHALL, on acceptance of the final sample of a window, register out_mean=(acc+in_value)>>WINDOW_LOG2 (truncating), update out_bit, and assert out_valid on the next cycle (1-cycle latency).
REQ-017 SHALL clear the accumulator in the same edge as REQ-016, so that the next window starts with zero and no sample is lost.
REQ-018 SHALL use a result FSM with states EMPTY and FULL: EMPTY->FULL on window complete; FULL->EMPTY on out_valid&&out_ready with no window completing in that cycle; FULL->FULL otherwise.
REQ-019 SHALL, when a window completes in the same cycle as out_valid&&out_ready, load the new result, stay FULL, and leave overrun unchanged.
REQ-020 SHALL, when a window completes in FULL without out_ready, overwrite the pending result with the new window and set overrun, which stays set until reset.
REQ-021 SHALL hold out_mean and out_bit stable while out_valid=1 and not consumed; out_valid SHALL equal (state==FULL).
REQ-022 SHALL, without hysteresis, compute out_bit=(mean > THRESHOLD).
REQ-023 SHALL compute threshold bounds with saturation at 0 and 2^INT_WIDTH-1, with no wrap-around.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-window, clear the accumulator, the counter, out_mean=0, out_bit=0, out_valid=0, overrun=0, and state=EMPTY immediately (asynchronously).
REQ-025 SHALL start the first window with the first in_valid after rst deasserts.

Configuration
REQ-026 SHALL, with macro DECODER_HYST_EN defined, set out_bit=1 if mean > THRESHOLD+HYST, set out_bit=0 if mean < THRESHOLD-HYST, and otherwise keep the previous out_bit.
REQ-027 SHALL, with DECODER_HYST_EN undefined, use REQ-022 and not reference HYST in logic.

Structure
REQ-028 SHALL place the result FSM state enum (EMPTY, FULL) and the saturating-bound helper constants in shared package snn_decode_pkg.
REQ-029 SHALL be implemented as a single module containing sub-module window_accumulator (the accumulator, counter, and last-sample strobe).

Verification (INT_WIDTH=8, WINDOW_LOG2=2, THRESHOLD=127, HYST=16, out_ready=1 unless stated)
REQ-030 SHALL test: samples 255,255,255,255 -> one cycle after the 4th sample, out_valid=1, out_mean=255, out_bit=1.
REQ-031 SHALL test: samples 0,255,0,255 -> out_mean=127, out_bit=0; in_valid=0 gaps between samples -> same result, and gap cycles are not counted.
REQ-032 SHALL test: out_ready=0 across two windows (255x4, then 0x4) -> out_mean=0, out_bit=0, overrun=1; out_ready=1 -> out_valid drops next cycle, and overrun stays 1.
REQ-033 SHALL test: a window completing in the same cycle as a consuming handshake -> new result is visible, out_valid stays 1, and overrun=0.
REQ-034 SHALL test: after out_bit=1, a window with mean 120 -> out_bit=1 with DECODER_HYST_EN and 0 without it; then mean 100 -> out_bit=0 in both builds.
REQ-035 SHALL test: rst pulse after 2 of 4 samples -> all outputs 0 at once, and the next 4 samples of 64 -> out_mean=64.

Source files
------------

// File: rtl/snn_decode_pkg.sv
// Shared types and helpers for the network output decoder: result FSM states
// and the saturating threshold-bound function.
package snn_decode_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

  localparam longint SAT_FLOOR = 0;

  // Clamp a bound into [0, 2^width-1] so THRESHOLD+/-HYST never wraps.
  function automatic longint sat_bound(input longint value, input int width);
    longint max_v;
    max_v = (longint'(1) << width) - 1;
    if (value < SAT_FLOOR) return SAT_FLOOR;
    if (value > max_v) return max_v;
    return value;
  endfunction

endpackage

// File: rtl/window_accumulator.sv
// Sums 2^WINDOW_LOG2 accepted samples; strobes last on the final sample and
// exposes the completed sum combinationally so no sample is lost at the boundary.
module window_accumulator #(
  parameter int INT_WIDTH   = 8,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [INT_WIDTH-1:0]             in_value,
  output logic                             last,
  output logic [INT_WIDTH+WINDOW_LOG2-1:0] sum
);

  localparam int ACC_W = INT_WIDTH + WINDOW_LOG2;

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;

  always_comb begin
    sum   = acc_q + ACC_W'(in_value);
    last  = in_valid && (cnt_q == '1);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = cnt_q + WINDOW_LOG2'(1);
      // The final sample closes the window and restarts from zero on the same edge.
      acc_d = last ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/network_output_decoder.sv
// Averages network output integers over a window and emits mean plus a binary
// decision through a one-entry result buffer. Optional hysteresis: DECODER_HYST_EN.
module network_output_decoder
  import snn_decode_pkg::*;
#(
  parameter int INT_WIDTH   = 8,
  parameter int WINDOW_LOG2 = 2,
  parameter int THRESHOLD   = ((1 << INT_WIDTH) - 1) / 2,
  parameter int HYST        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [INT_WIDTH-1:0] in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] out_mean,
  output logic                 out_bit,
  output logic                 overrun
);

  localparam int ACC_W = INT_WIDTH + WINDOW_LOG2;

  logic             win_last;
  logic [ACC_W-1:0] win_sum;

  window_accumulator #(
    .INT_WIDTH  (INT_WIDTH),
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_window_accumulator (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_value(in_value),
    .last    (win_last),
    .sum     (win_sum)
  );

  res_state_t           state_q, state_d;
  logic [INT_WIDTH-1:0] mean_q, mean_d;
  logic                 bit_q, bit_d;
  logic                 overrun_q, overrun_d;
  logic [INT_WIDTH-1:0] mean_new;
  logic                 bit_new;

  assign mean_new = win_sum[ACC_W-1:WINDOW_LOG2];

`ifdef DECODER_HYST_EN
  localparam logic [INT_WIDTH-1:0] HI_C =
    INT_WIDTH'(sat_bound(longint'(THRESHOLD) + longint'(HYST), INT_WIDTH));
  localparam logic [INT_WIDTH-1:0] LO_C =
    INT_WIDTH'(sat_bound(longint'(THRESHOLD) - longint'(HYST), INT_WIDTH));

  always_comb begin
    bit_new = bit_q;
    if (mean_new > HI_C) bit_new = 1'b1;
    else if (mean_new < LO_C) bit_new = 1'b0;
  end
`else
  localparam logic [INT_WIDTH-1:0] THR_C =
    INT_WIDTH'(sat_bound(longint'(THRESHOLD), INT_WIDTH));

  always_comb begin
    bit_new = (mean_new > THR_C);
  end
`endif

  always_comb begin
    state_d   = state_q;
    mean_d    = mean_q;
    bit_d     = bit_q;
    overrun_d = overrun_q;
    unique case (state_q)
      EMPTY: if (win_last) state_d = FULL;
      FULL: begin
        if (!win_last && out_ready) state_d = EMPTY;
        // A new window landing on an unconsumed result replaces it.
        if (win_last && !out_ready) overrun_d = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (win_last) begin
      mean_d = mean_new;
      bit_d  = bit_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      mean_q    <= '0;
      bit_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mean_q    <= mean_d;
      bit_q     <= bit_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_mean  = mean_q;
  assign out_bit   = bit_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_network_output_decoder.sv
// Scoreboard bench for network_output_decoder: directed scenarios plus random
// traffic, checked against a window-average reference model.
module tb_network_output_decoder;

  localparam int W    = 8;
  localparam int WL   = 2;
  localparam int N    = 1 << WL;
  localparam int THR  = 127;
  localparam int HYST = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_value = '0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_mean;
  logic         out_bit;
  logic         overrun;

  network_output_decoder #(
    .INT_WIDTH  (W),
    .WINDOW_LOG2(WL),
    .THRESHOLD  (THR),
    .HYST       (HYST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mean (out_mean),
    .out_bit  (out_bit),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int bitv;
  } result_t;

  result_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int samples[$];
  int pend      = 0;
  int ovr_m     = 0;
  int last_bit  = 0;
  int exp_valid = 0;
  int exp_ovr   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decide(input int mean);
`ifdef DECODER_HYST_EN
    int hi, lo;
    hi = (THR + HYST > 255) ? 255 : THR + HYST;
    lo = (THR - HYST < 0) ? 0 : THR - HYST;
    if (mean > hi) return 1;
    if (mean < lo) return 0;
    return last_bit;
`else
    return (mean > THR) ? 1 : 0;
`endif
  endfunction

  // One clock cycle of stimulus; the model advances to the post-edge state.
  task automatic cycle(input int v, input int val, input int rdy);
    int sum;
    int complete;
    result_t r;
    @(posedge clk);
    #1;
    exp_valid = pend;
    exp_ovr   = ovr_m;
    in_valid  = v[0];
    in_value  = W'(val);
    out_ready = rdy[0];
    complete  = 0;
    if (v != 0) begin
      samples.push_back(val);
      if (samples.size() == N) begin
        sum = 0;
        foreach (samples[i]) sum += samples[i];
        r.mean = sum / N;
        r.bitv = decide(r.mean);
        last_bit = r.bitv;
        samples.delete();
        complete = 1;
      end
    end
    if (complete != 0) begin
      if (pend != 0 && rdy == 0) begin
        q[q.size()-1] = r;
        ovr_m = 1;
      end else begin
        q.push_back(r);
      end
      pend = 1;
    end else if (pend != 0 && rdy != 0) begin
      pend = 0;
    end
  endtask

  task automatic window(input int val, input int rdy);
    for (int i = 0; i < N; i++) cycle(1, val, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},   int'(out_valid), 0);
    chk({tag, "_mean"},    int'(out_mean),  0);
    chk({tag, "_bit"},     int'(out_bit),   0);
    chk({tag, "_overrun"}, int'(overrun),   0);
  endtask

  // Monitor: checks handshake state every cycle and pops results on acceptance.
  initial begin
    result_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", int'(out_valid), exp_valid);
        chk("overrun", int'(overrun), exp_ovr);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            r = q.pop_front();
            $display("rx mean=%0d bit=%0d (exp %0d/%0d)", out_mean, out_bit, r.mean, r.bitv);
            chk("out_mean", int'(out_mean), r.mean);
            chk("out_bit", int'(out_bit), r.bitv);
          end
        end
      end
    end
  end

  initial begin
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturated window
    window(255, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Mean exactly at threshold, then same with gaps
    cycle(1, 0, 1); cycle(1, 255, 1); cycle(1, 0, 1); cycle(1, 255, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);
    cycle(1, 0, 1); cycle(0, 99, 1); cycle(1, 255, 1); cycle(0, 7, 1);
    cycle(0, 3, 1); cycle(1, 0, 1); cycle(0, 0, 1); cycle(1, 255, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);

    // Window completes on the same edge as a consuming handshake
    window(200, 0);
    cycle(1, 10, 0); cycle(1, 10, 0); cycle(1, 10, 0); cycle(1, 30, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);

    // Hysteresis band behaviour
    window(255, 1);
    window(120, 1);
    window(100, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);

    // Overwrite without consumption sets sticky overrun
    window(255, 0);
    window(0, 0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(0, 0, 1); cycle(0, 0, 1); cycle(0, 0, 1);

    // Asynchronous reset mid-window
    cycle(1, 200, 1); cycle(1, 200, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    samples.delete();
    q.delete();
    pend = 0; ovr_m = 0; last_bit = 0; exp_valid = 0; exp_ovr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    window(64, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int v, val, rdy;
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      val = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 255 : 0)
                                        : int'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 2) != 0) ? 1 : 0;
      cycle(v, val, rdy);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
